// File: rtl/oscope_pkg.sv
// Shared types and defaults for the oscilloscope capture path.
package oscope_pkg;

    localparam int DEFAULT_DEPTH = 8192;
    localparam int DEFAULT_AW    = 13;
    localparam int SAMPLE_W      = 8;

    typedef enum logic [2:0] {
        IDLE,
        PREFILL,
        WAIT_TRIG,
        POSTFILL,
        DONE
    } capstate_t;

endpackage

// File: rtl/trig_detect.sv
// Level-crossing detector: remembers the last written sample and flags a
// rising or falling crossing of the armed threshold on the current sample.
module trig_detect
    import oscope_pkg::*;
(
    input  logic                osc_clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic [SAMPLE_W-1:0] level,
    input  logic                falling,
    output logic                hit
);

    logic [SAMPLE_W-1:0] prev_sample;
    logic                prev_valid;
    logic                rising_hit;
    logic                falling_hit;

    always_ff @(posedge osc_clk) begin
        if (reset || clear) begin
            prev_sample <= '0;
            prev_valid  <= 1'b0;
        end else if (sample_valid) begin
            prev_sample <= sample_data;
            prev_valid  <= 1'b1;
        end
    end

    // Without a previous sample there is no edge to judge, so no hit.
    always_comb begin
        rising_hit  = (prev_sample < level) && (sample_data >= level);
        falling_hit = (prev_sample > level) && (sample_data <= level);
        hit         = sample_valid && prev_valid && (falling ? falling_hit : rising_hit);
    end

endmodule

// File: rtl/capture_ctrl.sv
// Trigger-and-capture sequencer feeding the circular sample buffer RAM.
// Optional forced trigger after a timeout in WAIT_TRIG: define CAPTURE_AUTO_TRIG_EN.
module capture_ctrl
    import oscope_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW
`ifdef CAPTURE_AUTO_TRIG_EN
    ,
    parameter int AUTO_TIMEOUT = 65535
`endif
) (
    input  logic                osc_clk,
    input  logic                reset,
    input  logic                arm,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic                trig_falling,
    input  logic [AW-1:0]       pretrig,
    output logic                mem_we,
    output logic [AW-1:0]       mem_waddr,
    output logic [SAMPLE_W-1:0] mem_wdata,
    output logic [AW-1:0]       start_adr,
    output logic                done_writing,
    output logic                busy,
    output logic                trig_forced
);

    localparam logic [AW:0]   DEPTH_X  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADR = AW'(DEPTH - 1);

    capstate_t           state;
    capstate_t           state_nx;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       pre_len;
    logic [AW-1:0]       pre_in;
    logic [AW-1:0]       post_len;
    logic [AW-1:0]       fill_cnt;
    logic [AW-1:0]       trig_start;
    logic [AW:0]         start_sum;
    logic [SAMPLE_W-1:0] level_q;
    logic                falling_q;
    logic                capturing;
    logic                wr_en;
    logic                hit;
    logic                forced_hit;
    logic                trig_fire;

    // The clamp only matters when the address width can express DEPTH or more.
    if ((1 << AW) > DEPTH) begin : g_clamp
        assign pre_in = (pretrig > LAST_ADR) ? LAST_ADR : pretrig;
    end else begin : g_noclamp
        assign pre_in = pretrig;
    end

    assign capturing = (state == PREFILL) || (state == WAIT_TRIG) || (state == POSTFILL);
    assign busy      = capturing;
    assign wr_en     = sample_valid && capturing && !arm;
    assign trig_fire = wr_en && (state == WAIT_TRIG) && (hit || forced_hit);
    assign post_len  = LAST_ADR - pre_len;
    assign start_sum = {1'b0, wr_ptr} + DEPTH_X - {1'b0, pre_len};
    assign trig_start = (start_sum >= DEPTH_X) ? AW'(start_sum - DEPTH_X) : start_sum[AW-1:0];

    trig_detect u_trig_detect (
        .osc_clk      (osc_clk),
        .reset        (reset),
        .clear        (arm),
        .sample_valid (wr_en),
        .sample_data  (sample_data),
        .level        (level_q),
        .falling      (falling_q),
        .hit          (hit)
    );

    always_ff @(posedge osc_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Arm overrides every state, including an in-flight capture.
    always_comb begin
        state_nx = state;
        if (arm) begin
            state_nx = (pre_in == '0) ? WAIT_TRIG : PREFILL;
        end else begin
            case (state)
                PREFILL:   if (wr_en && (fill_cnt + AW'(1) == pre_len)) state_nx = WAIT_TRIG;
                WAIT_TRIG: if (trig_fire) state_nx = (post_len == '0) ? DONE : POSTFILL;
                POSTFILL:  if (wr_en && (fill_cnt == AW'(1))) state_nx = DONE;
                default:   state_nx = state;
            endcase
        end
    end

    // fill_cnt counts up through PREFILL and down through POSTFILL.
    always_ff @(posedge osc_clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            pre_len      <= '0;
            fill_cnt     <= '0;
            level_q      <= '0;
            falling_q    <= 1'b0;
            mem_we       <= 1'b0;
            mem_waddr    <= '0;
            mem_wdata    <= '0;
            start_adr    <= '0;
            done_writing <= 1'b0;
        end else if (arm) begin
            wr_ptr       <= '0;
            fill_cnt     <= '0;
            pre_len      <= pre_in;
            level_q      <= trig_level;
            falling_q    <= trig_falling;
            mem_we       <= 1'b0;
            done_writing <= 1'b0;
        end else begin
            mem_we       <= wr_en;
            done_writing <= (state == DONE);
            if (wr_en) begin
                mem_waddr <= wr_ptr;
                mem_wdata <= sample_data;
                wr_ptr    <= (wr_ptr == LAST_ADR) ? '0 : wr_ptr + AW'(1);
            end
            if (trig_fire) begin
                start_adr <= trig_start;
                fill_cnt  <= post_len;
            end else if (wr_en && (state == PREFILL)) begin
                fill_cnt <= fill_cnt + AW'(1);
            end else if (wr_en && (state == POSTFILL)) begin
                fill_cnt <= fill_cnt - AW'(1);
            end
        end
    end

`ifdef CAPTURE_AUTO_TRIG_EN
    localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt;

    assign forced_hit = (to_cnt == TO_W'(AUTO_TIMEOUT - 1));

    // A genuine crossing on the timeout sample is not reported as forced.
    always_ff @(posedge osc_clk) begin
        if (reset || arm) begin
            to_cnt      <= '0;
            trig_forced <= 1'b0;
        end else begin
            if (wr_en && (state == WAIT_TRIG)) to_cnt <= to_cnt + TO_W'(1);
            if (trig_fire && !hit) trig_forced <= 1'b1;
        end
    end
`else
    assign forced_hit  = 1'b0;
    assign trig_forced = 1'b0;
`endif

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl with a 16-sample buffer.
module tb_capture_ctrl;

    localparam int DEPTH = 16;
    localparam int AW    = 5;
`ifdef CAPTURE_AUTO_TRIG_EN
    localparam int AUTO_TIMEOUT = 8;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic          osc_clk;
    logic          reset;
    logic          arm;
    logic          sample_valid;
    logic [7:0]    sample_data;
    logic [7:0]    trig_level;
    logic          trig_falling;
    logic [AW-1:0] pretrig;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic [AW-1:0] start_adr;
    logic          done_writing;
    logic          busy;
    logic          trig_forced;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  fails  = 0;

    capture_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
`ifdef CAPTURE_AUTO_TRIG_EN
        ,
        .AUTO_TIMEOUT (AUTO_TIMEOUT)
`endif
    ) dut (
        .osc_clk      (osc_clk),
        .reset        (reset),
        .arm          (arm),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .trig_level   (trig_level),
        .trig_falling (trig_falling),
        .pretrig      (pretrig),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .start_adr    (start_adr),
        .done_writing (done_writing),
        .busy         (busy),
        .trig_forced  (trig_forced)
    );

    initial begin
        osc_clk = 1'b0;
        forever #5 osc_clk = ~osc_clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
        end
    endtask

    // One sample, then two idle cycles; a write expectation is queued first.
    task automatic applyStimulus(input logic [7:0] d, input bit expect_wr, input int addr);
        wr_t e;
        if (expect_wr) begin
            e.addr = AW'(addr);
            e.data = d;
            exp_q.push_back(e);
        end
        @(posedge osc_clk); #1;
        sample_valid = 1'b1;
        sample_data  = d;
        @(posedge osc_clk); #1;
        sample_valid = 1'b0;
        @(posedge osc_clk); #1;
    endtask

    task automatic doArm(input logic [AW-1:0] pre, input logic [7:0] lvl, input logic fall, input bit with_sample);
        @(posedge osc_clk); #1;
        arm          = 1'b1;
        pretrig      = pre;
        trig_level   = lvl;
        trig_falling = fall;
        if (with_sample) begin
            sample_valid = 1'b1;
            sample_data  = 8'hEE;
        end
        @(posedge osc_clk); #1;
        arm          = 1'b0;
        sample_valid = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mem_we"}, 32'(mem_we), 0);
        checkOutput({tag, "_mem_waddr"}, 32'(mem_waddr), 0);
        checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        checkOutput({tag, "_start_adr"}, 32'(start_adr), 0);
        checkOutput({tag, "_done"}, 32'(done_writing), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_trig_forced"}, 32'(trig_forced), 0);
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge osc_clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_write: actual addr %0d data %0d required no write",
                         mem_waddr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("write_addr", 32'(mem_waddr), 32'(mon_e.addr));
                checkOutput("write_data", 32'(mem_wdata), 32'(mon_e.data));
            end
        end
    end

    initial begin
        repeat (20000) @(posedge osc_clk);
        $display("[TB] FAIL watchdog: actual still running required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        arm          = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        trig_level   = '0;
        trig_falling = 1'b0;
        pretrig      = '0;
        repeat (3) @(posedge osc_clk);
        #1;
        checkAllZero("reset");
        reset = 1'b0;

        // Rising ramp, pretrig 4: trigger on 100 at address 4, last write is sample 111.
        $display("[TB] ramp capture");
        doArm(5'd4, 8'd100, 1'b0, 1'b0);
        checkOutput("arm_busy", 32'(busy), 1);
        checkOutput("arm_done", 32'(done_writing), 0);
        for (int k = 0; k <= 120; k++) begin
            applyStimulus(8'(k), (k <= 111), k % 16);
            if (k == 110) checkOutput("ramp_done_before_last", 32'(done_writing), 0);
        end
        checkOutput("ramp_done", 32'(done_writing), 1);
        checkOutput("ramp_start_adr", 32'(start_adr), 0);
        checkOutput("ramp_busy", 32'(busy), 0);

        // pretrig 0: 200 first cannot trigger, 50->150 triggers at address 2.
        $display("[TB] pretrig zero capture");
        doArm(5'd0, 8'd100, 1'b0, 1'b0);
        checkOutput("rearm_done_falls", 32'(done_writing), 0);
        checkOutput("rearm_busy", 32'(busy), 1);
        applyStimulus(8'd200, 1'b1, 0);
        applyStimulus(8'd50, 1'b1, 1);
        applyStimulus(8'd150, 1'b1, 2);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(8'(10 + i), 1'b1, (3 + i) % 16);
            if (i == 13) checkOutput("pre0_done_before_last", 32'(done_writing), 0);
        end
        applyStimulus(8'd77, 1'b0, 0);
        applyStimulus(8'd77, 1'b0, 0);
        checkOutput("pre0_done", 32'(done_writing), 1);
        checkOutput("pre0_start_adr", 32'(start_adr), 2);

        // Falling slope: 120 does not cross 100, 90 does (address 2).
        $display("[TB] falling capture");
        doArm(5'd0, 8'd100, 1'b1, 1'b0);
        applyStimulus(8'd150, 1'b1, 0);
        applyStimulus(8'd120, 1'b1, 1);
        applyStimulus(8'd90, 1'b1, 2);
        for (int i = 0; i < 15; i++) applyStimulus(8'd60, 1'b1, (3 + i) % 16);
        applyStimulus(8'd60, 1'b0, 0);
        checkOutput("fall_done", 32'(done_writing), 1);
        checkOutput("fall_start_adr", 32'(start_adr), 2);

        // Abort during POSTFILL with a simultaneous sample that must be dropped.
        $display("[TB] abort during postfill");
        doArm(5'd4, 8'd100, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(8'd10, 1'b1, i);
        applyStimulus(8'd50, 1'b1, 4);
        applyStimulus(8'd150, 1'b1, 5);
        applyStimulus(8'd160, 1'b1, 6);
        applyStimulus(8'd170, 1'b1, 7);
        doArm(5'd4, 8'd100, 1'b0, 1'b1);
        checkOutput("abort_done", 32'(done_writing), 0);
        checkOutput("abort_busy", 32'(busy), 1);
        applyStimulus(8'd33, 1'b1, 0);
        checkOutput("abort_done_later", 32'(done_writing), 0);

        // pretrig 20 clamps to 15: DONE right after the trigger write.
        $display("[TB] clamped pretrig");
        doArm(5'd20, 8'd100, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) applyStimulus(8'd10, 1'b1, i);
        applyStimulus(8'd50, 1'b1, 15);
        applyStimulus(8'd150, 1'b1, 0);
        checkOutput("clamp_done", 32'(done_writing), 1);
        checkOutput("clamp_start_adr", 32'(start_adr), 1);
        checkOutput("clamp_busy", 32'(busy), 0);
        applyStimulus(8'd99, 1'b0, 0);
        checkOutput("clamp_done_hold", 32'(done_writing), 1);

`ifdef CAPTURE_AUTO_TRIG_EN
        // Constant input forces a trigger on the 8th WAIT_TRIG sample (address 7).
        $display("[TB] auto trigger");
        doArm(5'd0, 8'd100, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'd20, 1'b1, i);
            if (i == 6) checkOutput("auto_not_yet", 32'(trig_forced), 0);
        end
        checkOutput("auto_forced", 32'(trig_forced), 1);
        for (int i = 0; i < 15; i++) applyStimulus(8'd20, 1'b1, (8 + i) % 16);
        checkOutput("auto_done", 32'(done_writing), 1);
        checkOutput("auto_start_adr", 32'(start_adr), 7);
        checkOutput("auto_forced_hold", 32'(trig_forced), 1);
        doArm(5'd0, 8'd100, 1'b0, 1'b0);
        checkOutput("auto_forced_cleared", 32'(trig_forced), 0);
        applyStimulus(8'd20, 1'b1, 0);
        applyStimulus(8'd20, 1'b1, 1);
`else
        // Without the timeout, WAIT_TRIG waits indefinitely on a flat input.
        $display("[TB] no auto trigger");
        doArm(5'd0, 8'd100, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(8'd20, 1'b1, i);
        checkOutput("wait_busy", 32'(busy), 1);
        checkOutput("wait_done", 32'(done_writing), 0);
        checkOutput("wait_forced", 32'(trig_forced), 0);
`endif

        // Reset in WAIT_TRIG with a sample present: no strobe, everything cleared.
        $display("[TB] reset mid capture");
        @(posedge osc_clk); #1;
        reset        = 1'b1;
        sample_valid = 1'b1;
        sample_data  = 8'd55;
        @(posedge osc_clk); #1;
        reset        = 1'b0;
        sample_valid = 1'b0;
        checkAllZero("midreset");
        repeat (3) @(posedge osc_clk);
        #1;
        checkOutput("pending_writes", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
